// File: rtl/data_mover_bram_stream_out_pkg.sv
// rtl/data_mover_bram_stream_out_pkg.sv - shared state encodings and defaults for the BRAM1 stream-out mover
package data_mover_bram_stream_out_pkg;

    // State encodings are shared with the other data movers so one controller sequences them all
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int DEF_CNT_BIT    = 31;
    localparam int DEF_DWIDTH     = 56;
    localparam int DEF_AWIDTH     = 12;
    localparam int DEF_MEM_SIZE   = 4096;
    localparam int DEF_FIFO_DEPTH = 4;

    // A new read may issue only if the word it returns is guaranteed a FIFO slot;
    // occupancy counts words already stored plus the one still in the BRAM pipeline.
    function automatic logic has_credit(input int unsigned occupancy, input int unsigned depth);
        return (occupancy + 1) <= depth;
    endfunction

endpackage

// File: rtl/data_mover_bram_stream_out_sync_fifo.sv
// rtl/data_mover_bram_stream_out_sync_fifo.sv - first-word-fall-through synchronous FIFO
module sync_fifo_fwft #(
    parameter  int WIDTH  = 56,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Status and head word; the head is forced to zero when empty so stale storage never shows
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        m_tvalid = (count_q != '0);
        m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
        pop      = m_tvalid && m_tready;
        push     = s_tvalid && (!full || pop);
        count_o  = count_q;
    end

    // Next pointers, occupancy and storage writes; simultaneous push and pop leaves count unchanged
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_tdata;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed behind a valid count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/data_mover_bram_stream_out.sv
// rtl/data_mover_bram_stream_out.sv - drains BRAM1 sequentially onto a valid/ready stream
module data_mover_bram_stream_out
    import data_mover_bram_stream_out_pkg::*;
#(
    parameter int CNT_BIT    = DEF_CNT_BIT,
    parameter int DWIDTH_P   = DEF_DWIDTH,
    parameter int AWIDTH     = DEF_AWIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_run_i,
    input  logic [CNT_BIT-1:0]  run_count_i,
    output logic                idle_o,
    output logic                run_o,
    output logic                done_o,
    output logic [AWIDTH-1:0]   addr_b1_o,
    output logic                ce_b1_o,
    output logic                we_b1_o,
    output logic [DWIDTH_P-1:0] d_b1_o,
    input  logic [DWIDTH_P-1:0] q_b1_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [DWIDTH_P-1:0] m_data_o,
    output logic                m_last_o
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    // Reject configurations that cannot work at all
    if (MEM_SIZE < 1 || FIFO_DEPTH < 1 || CNT_BIT < AWIDTH) begin : g_bad_params
        $error("data_mover_bram_stream_out: invalid parameter set");
    end

    state_e              state_q, state_d;
    logic [CNT_BIT-1:0]  num_cnt_q, num_cnt_d;
    logic [CNT_BIT-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_BIT-1:0]  out_cnt_q, out_cnt_d;
    logic                r_valid_q, r_valid_d;

    logic [FCW-1:0]      fifo_count;
    logic                fifo_valid;
    logic [DWIDTH_P-1:0] fifo_data;
    logic                credit_ok;
    logic                rd_issue;
    logic                pop;
    logic                last_beat;

    // Output buffer: the word returned by BRAM1 one cycle after a read is pushed unconditionally
    sync_fifo_fwft #(
        .WIDTH (DWIDTH_P),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (reset_n),
        .s_tdata  (q_b1_i),
        .s_tvalid (r_valid_q),
        .m_tdata  (fifo_data),
        .m_tvalid (fifo_valid),
        .m_tready (m_ready_i),
        .count_o  (fifo_count)
    );

    // Read issue is gated by credit so an in-flight word always has somewhere to land
    always_comb begin
        credit_ok = has_credit(32'(fifo_count) + 32'(r_valid_q), 32'(FIFO_DEPTH));
        rd_issue  = (state_q == S_RUN) && (rd_cnt_q < num_cnt_q) && credit_ok;
        pop       = fifo_valid && m_ready_i;
        last_beat = fifo_valid && (out_cnt_q == num_cnt_q - CNT_BIT'(1));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a zero-length run goes straight to DONE, RUN ends on the final handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_run_i) begin
                    state_d = (run_count_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath outputs
    always_comb begin
        idle_o    = (state_q == S_IDLE);
        run_o     = (state_q == S_RUN);
        done_o    = (state_q == S_DONE);
        ce_b1_o   = rd_issue;
        addr_b1_o = rd_cnt_q[AWIDTH-1:0];
        we_b1_o   = 1'b0;
        d_b1_o    = '0;
        m_valid_o = fifo_valid;
        m_data_o  = fifo_data;
        m_last_o  = last_beat;
    end

    // Counter updates: a start in IDLE latches N and clears the read and output counters
    always_comb begin
        num_cnt_d = num_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        r_valid_d = rd_issue;
        if ((state_q == S_IDLE) && start_run_i) begin
            num_cnt_d = run_count_i;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (rd_issue) begin
                rd_cnt_d = rd_cnt_q + CNT_BIT'(1);
            end
            if (pop) begin
                out_cnt_d = out_cnt_q + CNT_BIT'(1);
            end
        end
    end

    // Counter and read-pipeline registers; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_cnt_q <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            r_valid_q <= 1'b0;
        end else begin
            num_cnt_q <= num_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            r_valid_q <= r_valid_d;
        end
    end

endmodule

// File: tb/tb_data_mover_bram_stream_out.sv
// tb/tb_data_mover_bram_stream_out.sv - scoreboard bench for the BRAM1 stream-out mover
module tb_data_mover_bram_stream_out;

    localparam int CB = 31;
    localparam int DW = 56;
    localparam int AW = 12;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_run_i = 1'b0;
    logic [CB-1:0] run_count_i = '0;
    logic          idle_o, run_o, done_o;
    logic [AW-1:0] addr_b1_o;
    logic          ce_b1_o, we_b1_o;
    logic [DW-1:0] d_b1_o;
    logic [DW-1:0] q_b1_i = '0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;

    logic [DW-1:0] mem_base = '0;
    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass = 0;

    data_mover_bram_stream_out dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_run_i (start_run_i),
        .run_count_i (run_count_i),
        .idle_o      (idle_o),
        .run_o       (run_o),
        .done_o      (done_o),
        .addr_b1_o   (addr_b1_o),
        .ce_b1_o     (ce_b1_o),
        .we_b1_o     (we_b1_o),
        .d_b1_o      (d_b1_o),
        .q_b1_i      (q_b1_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_last_o    (m_last_o)
    );

    always #5 clk = ~clk;

    // BRAM1 model: mem[a] = mem_base + a, one cycle read latency
    always @(posedge clk) begin
        if (ce_b1_o) q_b1_i <= mem_base + DW'(addr_b1_o);
    end

    task automatic drive_start(input int n, input logic [DW-1:0] base);
        exp_t e;
        mem_base    = base;
        run_count_i = CB'(n);
        start_run_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            e.data = base + DW'(i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start_run_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({idle_o, run_o, done_o} !== 3'b100) $display("FAIL reset_state: got %b want 100", {idle_o, run_o, done_o});
        else n_pass++;
        n_checks++;
        if ({ce_b1_o, we_b1_o, m_valid_o, m_last_o} !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", {ce_b1_o, we_b1_o, m_valid_o, m_last_o});
        else n_pass++;
        n_checks++;
        if (m_data_o !== '0 || d_b1_o !== '0) $display("FAIL reset_data: got m_data %0h d %0h want 0", m_data_o, d_b1_o);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        int first_ce = -1, first_v = -1, last_cyc = -1, last_cnt = 0;
        int done_cyc = -1, idle_cyc = -1, beats = 0;
        m_ready_i = 1'b1;
        drive_start(4, 56'h10);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ce_b1_o && first_ce < 0) first_ce = c;
            if (m_valid_o && first_v < 0) first_v = c;
            if (m_last_o) begin last_cnt++; last_cyc = c; end
            if (done_o && done_cyc < 0) done_cyc = c;
            if (idle_o && idle_cyc < 0) idle_cyc = c;
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL basic_beat: got extra %0h want none", m_data_o);
                else begin
                    e = sb.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last || c !== 3 + beats)
                        $display("FAIL basic_beat: got %0h/%b cyc %0d want %0h/%b cyc %0d", m_data_o, m_last_o, c, e.data, e.last, 3 + beats);
                    else n_pass++;
                end
                beats++;
            end
        end
        n_checks++;
        if (first_ce !== 1 || first_v !== 3) $display("FAIL basic_latency: got ce %0d valid %0d want 1 3", first_ce, first_v);
        else n_pass++;
        n_checks++;
        if (last_cnt !== 1 || last_cyc !== 6) $display("FAIL basic_last: got %0d at %0d want 1 at 6", last_cnt, last_cyc);
        else n_pass++;
        n_checks++;
        if (done_cyc !== 7 || idle_cyc !== 8) $display("FAIL basic_done_idle: got %0d %0d want 7 8", done_cyc, idle_cyc);
        else n_pass++;
        n_checks++;
        if (beats !== 4 || sb.size() !== 0) $display("FAIL basic_count: got %0d left %0d want 4 0", beats, sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int issued = 0, popped = 0, max_out = 0, credit_viol = 0, credit_stall = 0;
        int addr_err = 0, stab_err = 0, done_cyc = -1;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        m_ready_i = 1'b0;
        drive_start(16, 56'h1000);
        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            m_ready_i = (c <= 8) ? 1'b0 : 1'($urandom_range(0, 1));
            if (prev_stall && (!m_valid_o || m_data_o !== prev_data)) stab_err++;
            if (issued - popped > max_out) max_out = issued - popped;
            if (ce_b1_o) begin
                if (issued - popped >= 4) credit_viol++;
                if (addr_b1_o !== AW'(issued)) addr_err++;
                issued++;
            end else if (run_o && issued < 16 && issued - popped == 4) begin
                credit_stall++;
            end
            if (done_o) done_cyc = c;
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL bp_beat: got extra %0h want none", m_data_o);
                else begin
                    e = sb.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last)
                        $display("FAIL bp_beat: got %0h/%b want %0h/%b", m_data_o, m_last_o, e.data, e.last);
                    else n_pass++;
                end
                popped++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
        end
        m_ready_i = 1'b1;
        n_checks++;
        if (popped !== 16 || sb.size() !== 0 || done_cyc < 0) $display("FAIL bp_count: got %0d left %0d done %0d want 16 0 >0", popped, sb.size(), done_cyc);
        else n_pass++;
        n_checks++;
        if (max_out > 4 || credit_viol !== 0) $display("FAIL bp_credit: got max %0d viol %0d want <=4 0", max_out, credit_viol);
        else n_pass++;
        n_checks++;
        if (credit_stall == 0) $display("FAIL bp_ce_stall: got %0d stalled cycles want >0", credit_stall);
        else n_pass++;
        n_checks++;
        if (addr_err !== 0 || stab_err !== 0) $display("FAIL bp_addr_stable: got addr_err %0d stab_err %0d want 0 0", addr_err, stab_err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (idle_o !== 1'b1) $display("FAIL bp_idle: got %b want 1", idle_o);
        else n_pass++;
    endtask

    task automatic test_zero();
        int ce_seen = 0, v_seen = 0, done_cyc = -1;
        logic idle_c2 = 1'b0;
        m_ready_i = 1'b1;
        drive_start(0, 56'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (ce_b1_o) ce_seen++;
            if (m_valid_o) v_seen++;
            if (done_o && done_cyc < 0) done_cyc = c;
            if (c == 2) idle_c2 = idle_o;
        end
        n_checks++;
        if (done_cyc !== 1 || idle_c2 !== 1'b1) $display("FAIL zero_done: got done %0d idle %b want 1 1", done_cyc, idle_c2);
        else n_pass++;
        n_checks++;
        if (ce_seen !== 0 || v_seen !== 0) $display("FAIL zero_quiet: got ce %0d valid %0d want 0 0", ce_seen, v_seen);
        else n_pass++;
    endtask

    task automatic test_stall();
        exp_t e;
        int issued = 0, stalled_issued = -1, addr_err = 0, beats = 0, last_idx = -1, done_cyc = -1;
        m_ready_i = 1'b0;
        drive_start(8, 56'h2000);
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            m_ready_i = (c > 20);
            if (ce_b1_o) begin
                if (addr_b1_o !== AW'(issued)) addr_err++;
                issued++;
            end
            if (c == 20) stalled_issued = issued;
            if (done_o) done_cyc = c;
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL stall_beat: got extra %0h want none", m_data_o);
                else begin
                    e = sb.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last)
                        $display("FAIL stall_beat: got %0h/%b want %0h/%b", m_data_o, m_last_o, e.data, e.last);
                    else n_pass++;
                end
                if (m_last_o) last_idx = beats;
                beats++;
            end
        end
        m_ready_i = 1'b1;
        n_checks++;
        if (stalled_issued !== 4 || addr_err !== 0) $display("FAIL stall_reads: got %0d addr_err %0d want 4 0", stalled_issued, addr_err);
        else n_pass++;
        n_checks++;
        if (beats !== 8 || last_idx !== 7 || sb.size() !== 0 || done_cyc < 0) $display("FAIL stall_drain: got %0d last %0d done %0d want 8 7 >0", beats, last_idx, done_cyc);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int beats = 0, first_addr = -1, done_cyc = -1;
        m_ready_i = 1'b1;
        drive_start(10, 56'h5000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                e = sb.pop_front();
                if (m_data_o !== e.data) $display("FAIL rmid_pre_beat: got %0h want %0h", m_data_o, e.data);
                else n_pass++;
            end
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if ({idle_o, run_o, done_o, ce_b1_o, m_valid_o, m_last_o} !== 6'b100000 || m_data_o !== '0)
            $display("FAIL rmid_reset_vals: got %b data %0h want 100000 0", {idle_o, run_o, done_o, ce_b1_o, m_valid_o, m_last_o}, m_data_o);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        drive_start(3, 56'h6000);
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (ce_b1_o && first_addr < 0) first_addr = int'(addr_b1_o);
            if (done_o) done_cyc = c;
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL rmid_beat: got extra %0h want none", m_data_o);
                else begin
                    e = sb.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last)
                        $display("FAIL rmid_beat: got %0h/%b want %0h/%b", m_data_o, m_last_o, e.data, e.last);
                    else n_pass++;
                end
                beats++;
            end
        end
        n_checks++;
        if (first_addr !== 0 || beats !== 3 || done_cyc !== 6) $display("FAIL rmid_rerun: got addr %0d beats %0d done %0d want 0 3 6", first_addr, beats, done_cyc);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_restart_ignored();
        exp_t e;
        int beats = 0, done_cyc = -1;
        m_ready_i = 1'b1;
        drive_start(5, 56'h3000);
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 2) begin start_run_i = 1'b1; run_count_i = CB'(9); end
            else start_run_i = 1'b0;
            if (done_o) done_cyc = c;
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL restart_beat: got extra %0h want none", m_data_o);
                else begin
                    e = sb.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last)
                        $display("FAIL restart_beat: got %0h/%b want %0h/%b", m_data_o, m_last_o, e.data, e.last);
                    else n_pass++;
                end
                beats++;
            end
        end
        start_run_i = 1'b0;
        n_checks++;
        if (beats !== 5 || done_cyc !== 8 || sb.size() !== 0) $display("FAIL restart_ignored: got %0d done %0d want 5 8", beats, done_cyc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (idle_o !== 1'b1) $display("FAIL b2b_idle: got %b want 1", idle_o);
        else n_pass++;
        beats = 0;
        done_cyc = -1;
        drive_start(2, 56'h4000);
        for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (done_o) done_cyc = c;
            if (m_valid_o && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL b2b_beat: got extra %0h want none", m_data_o);
                else begin
                    e = sb.pop_front();
                    if (m_data_o !== e.data || m_last_o !== e.last)
                        $display("FAIL b2b_beat: got %0h/%b want %0h/%b", m_data_o, m_last_o, e.data, e.last);
                    else n_pass++;
                end
                beats++;
            end
        end
        n_checks++;
        if (beats !== 2 || done_cyc !== 5) $display("FAIL b2b_run: got %0d done %0d want 2 5", beats, done_cyc);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_stall();
        test_reset_mid();
        test_restart_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
